// File: rtl/prim_fetch_pkg.sv
// ============================================================================
// prim_fetch_pkg : shared constants and types for the primitive fetch sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package prim_fetch_pkg;

  localparam logic [1:0] PT_LINE = 2'b00;
  localparam logic [1:0] PT_TRI  = 2'b01;
  localparam logic [1:0] PT_RSVD = 2'b10;
  localparam logic [1:0] PT_END  = 2'b11;

  localparam int TYPE_MSB     = 31;
  localparam int TYPE_LSB     = 30;
  localparam int ATTR_MSB     = 29;
  localparam int RECORD_WORDS = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_OUT   = 2'b10,
    S_FIN   = 2'b11
  } state_e;

endpackage

`default_nettype wire

// File: rtl/prim_fetch_if.sv
// ============================================================================
// prim_fetch_if : primitive hand-off bus between fetch sequencer and rasterizer
// Rev 1.0
// ============================================================================
`default_nettype none

interface prim_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  prim_valid;
  logic                  prim_ready;
  logic [1:0]            prim_type;
  logic [29:0]           prim_attr;
  logic [DATA_WIDTH-1:0] prim_v0;
  logic [DATA_WIDTH-1:0] prim_v1;
  logic [DATA_WIDTH-1:0] prim_v2;

  modport master (
    output prim_valid, prim_type, prim_attr, prim_v0, prim_v1, prim_v2,
    input  prim_ready
  );

  modport slave (
    input  prim_valid, prim_type, prim_attr, prim_v0, prim_v1, prim_v2,
    output prim_ready
  );
endinterface

`default_nettype wire

// File: rtl/prim_fetch.sv
// ============================================================================
// prim_fetch : walks a list of 4-word primitive records in RAM and hands
//              line/triangle primitives to the rasterizer
// Rev 1.0
// ============================================================================
`default_nettype none

module prim_fetch
  import prim_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  start,
  input  wire logic [ADDR_WIDTH-1:0] base_addr,
  input  wire logic [ADDR_WIDTH-2:0] prim_count,
  output logic      [ADDR_WIDTH-1:0] rd_addr,
  input  wire logic [DATA_WIDTH-1:0] rd_data0,
  input  wire logic [DATA_WIDTH-1:0] rd_data1,
  input  wire logic [DATA_WIDTH-1:0] rd_data2,
  input  wire logic [DATA_WIDTH-1:0] rd_data3,
  prim_fetch_if.master               pif,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  state_e                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [ADDR_WIDTH-2:0]   r_count, w_count_nxt;
  logic                    r_err, w_err_nxt;
  logic [1:0]              r_type, w_type_nxt;
  logic [29:0]             r_attr, w_attr_nxt;
  logic [DATA_WIDTH-1:0]   r_v0, w_v0_nxt;
  logic [DATA_WIDTH-1:0]   r_v1, w_v1_nxt;
  logic [DATA_WIDTH-1:0]   r_v2, w_v2_nxt;

  logic [1:0]              w_hdr_type;
  logic [ADDR_WIDTH-1:0]   w_addr_inc;
  logic [ADDR_WIDTH-2:0]   w_count_dec;
  logic [ADDR_WIDTH-1:0]   w_base_aligned;

  assign w_hdr_type     = rd_data0[TYPE_MSB:TYPE_LSB];
  // Records are 4-aligned, so the increment wraps cleanly at the top of RAM.
  assign w_addr_inc     = r_addr + ADDR_WIDTH'(RECORD_WORDS);
  assign w_count_dec    = r_count - 1'b1;
  assign w_base_aligned = base_addr & ~ADDR_WIDTH'(RECORD_WORDS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_type  <= '0;
      r_attr  <= '0;
      r_v0    <= '0;
      r_v1    <= '0;
      r_v2    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_type  <= w_type_nxt;
      r_attr  <= w_attr_nxt;
      r_v0    <= w_v0_nxt;
      r_v1    <= w_v1_nxt;
      r_v2    <= w_v2_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_type_nxt  = r_type;
    w_attr_nxt  = r_attr;
    w_v0_nxt    = r_v0;
    w_v1_nxt    = r_v1;
    w_v2_nxt    = r_v2;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_addr_nxt  = w_base_aligned;
          w_count_nxt = prim_count;
          w_err_nxt   = 1'b0;
          w_state_nxt = (prim_count == '0) ? S_FIN : S_FETCH;
        end
      end

      S_FETCH: begin
        case (w_hdr_type)
          PT_LINE, PT_TRI: begin
            w_type_nxt  = w_hdr_type;
            w_attr_nxt  = rd_data0[ATTR_MSB:0];
            w_v0_nxt    = rd_data1;
            w_v1_nxt    = rd_data2;
            w_v2_nxt    = (w_hdr_type == PT_LINE) ? '0 : rd_data3;
            w_state_nxt = S_OUT;
          end
          PT_RSVD: begin
            w_err_nxt   = 1'b1;
            w_addr_nxt  = w_addr_inc;
            w_count_nxt = w_count_dec;
            w_state_nxt = (w_count_dec != '0) ? S_FETCH : S_FIN;
          end
          // END marker: stop without consuming a count
          default: w_state_nxt = S_FIN;
        endcase
      end

      S_OUT: begin
        if (pif.prim_ready) begin
          w_addr_nxt  = w_addr_inc;
          w_count_nxt = w_count_dec;
          w_state_nxt = (w_count_dec != '0) ? S_FETCH : S_FIN;
        end
      end

      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rd_addr        = r_addr;
  assign busy           = (r_state == S_FETCH) || (r_state == S_OUT);
  assign done           = (r_state == S_FIN);
  assign err            = r_err;
  assign pif.prim_valid = (r_state == S_OUT);
  assign pif.prim_type  = r_type;
  assign pif.prim_attr  = r_attr;
  assign pif.prim_v0    = r_v0;
  assign pif.prim_v1    = r_v1;
  assign pif.prim_v2    = r_v2;

endmodule

`default_nettype wire

// File: tb/tb_prim_fetch.sv
// ============================================================================
// tb_prim_fetch : self-checking bench for prim_fetch with a RAM model and a
//                 primitive scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prim_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [6:0]  prim_count = '0;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data0, rd_data1, rd_data2, rd_data3;
  logic        busy, done, err;

  logic [31:0] mem [256];

  prim_fetch_if #(.DATA_WIDTH(32)) pif ();

  prim_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .prim_count (prim_count),
    .rd_addr    (rd_addr),
    .rd_data0   (rd_data0),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .rd_data3   (rd_data3),
    .pif        (pif),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign rd_data0 = mem[rd_addr];
  assign rd_data1 = mem[8'(rd_addr + 8'd1)];
  assign rd_data2 = mem[8'(rd_addr + 8'd2)];
  assign rd_data3 = mem[8'(rd_addr + 8'd3)];

  typedef struct {
    logic [1:0]  t;
    logic [29:0] a;
    logic [31:0] v0, v1, v2;
  } prim_t;

  typedef struct {
    logic [31:0] hdr, v0, v1, v2;
    logic        emit;
    logic [1:0]  etype;
    logic [29:0] eattr;
    logic [31:0] ev2;
    logic        eerr;
    logic [7:0]  eaddr_off;
  } vec_t;

  prim_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    prim_cnt = 0;
  int    done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: compare each accepted primitive against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && pif.prim_valid && pif.prim_ready) begin
      prim_cnt++;
      if (sb.size() == 0) begin
        check("sb_unexpected_prim", 64'd1, 64'd0);
      end else begin
        prim_t e;
        e = sb.pop_front();
        check("sb_type", 64'(pif.prim_type), 64'(e.t));
        check("sb_attr", 64'(pif.prim_attr), 64'(e.a));
        check("sb_v0",   64'(pif.prim_v0),   64'(e.v0));
        check("sb_v1",   64'(pif.prim_v1),   64'(e.v1));
        check("sb_v2",   64'(pif.prim_v2),   64'(e.v2));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic load_rec(input logic [7:0] a, input logic [31:0] h, v0, v1, v2);
    mem[a]               = h;
    mem[8'(a + 8'd1)]    = v0;
    mem[8'(a + 8'd2)]    = v1;
    mem[8'(a + 8'd3)]    = v2;
  endtask

  task automatic push_exp(input logic [1:0] t, input logic [29:0] a,
                          input logic [31:0] v0, v1, v2);
    prim_t p;
    p.t = t; p.a = a; p.v0 = v0; p.v1 = v1; p.v2 = v2;
    sb.push_back(p);
  endtask

  task automatic do_start(input logic [7:0] b, input logic [6:0] c);
    @(negedge clk);
    base_addr  = b;
    prim_count = c;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_timeout"}, 64'(k < 200), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (pif.prim_valid !== 1'b1 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, "_valid_timeout"}, 64'(k < 200), 64'd1);
  endtask

  vec_t vecs[5];

  initial begin
    int p0, d0;
    logic [7:0] b;
    prim_t snap;

    vecs[0] = '{32'h0000_00FF, 32'h000A_0014, 32'h0032_0028, 32'hDEAD_BEEF,
                1'b1, 2'b00, 30'h0000_00FF, 32'h0, 1'b0, 8'd4};
    vecs[1] = '{32'h4000_1234, 32'h0001_0002, 32'h0003_0004, 32'h1111_2222,
                1'b1, 2'b01, 30'h0000_1234, 32'h1111_2222, 1'b0, 8'd4};
    vecs[2] = '{32'h8000_0001, 32'h5, 32'h6, 32'h7,
                1'b0, 2'b00, 30'h0, 32'h0, 1'b1, 8'd4};
    vecs[3] = '{32'hC000_0000, 32'h5, 32'h6, 32'h7,
                1'b0, 2'b00, 30'h0, 32'h0, 1'b0, 8'd0};
    vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'hA5A5_5A5A,
                1'b1, 2'b01, 30'h3FFF_FFFF, 32'hA5A5_5A5A, 1'b0, 8'd4};

    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000;
    pif.prim_ready = 1'b0;

    // Reset state
    #23;
    check("rst_valid", 64'(pif.prim_valid), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_err",   64'(err), 64'd0);
    check("rst_addr",  64'(rd_addr), 64'd0);
    check("rst_v0",    64'(pif.prim_v0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-record vectors
    pif.prim_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b = 8'(8'h40 + 16 * i);
      load_rec(b, vecs[i].hdr, vecs[i].v0, vecs[i].v1, vecs[i].v2);
      if (vecs[i].emit)
        push_exp(vecs[i].etype, vecs[i].eattr, vecs[i].v0, vecs[i].v1, vecs[i].ev2);
      p0 = prim_cnt; d0 = done_cnt;
      do_start(b, 7'd1);
      wait_done($sformatf("vec%0d", i));
      check($sformatf("vec%0d_err", i),   64'(err), 64'(vecs[i].eerr));
      check($sformatf("vec%0d_prims", i), 64'(prim_cnt - p0), 64'(vecs[i].emit));
      check($sformatf("vec%0d_dones", i), 64'(done_cnt - d0), 64'd1);
      check($sformatf("vec%0d_addr", i),  64'(rd_addr), 64'(8'(b + vecs[i].eaddr_off)));
    end

    // Basic walk with latency
    load_rec(8'h00, 32'h0000_00FF, 32'h000A_0014, 32'h0032_0028, 32'h1234_5678);
    push_exp(2'b00, 30'hFF, 32'h000A_0014, 32'h0032_0028, 32'h0);
    p0 = prim_cnt;
    do_start(8'h00, 7'd1);
    check("basic_busy_fetch", 64'(busy), 64'd1);
    check("basic_valid_early", 64'(pif.prim_valid), 64'd0);
    @(posedge clk); #1;
    check("basic_valid", 64'(pif.prim_valid), 64'd1);
    @(posedge clk); #1;
    check("basic_done", 64'(done), 64'd1);
    check("basic_valid_drop", 64'(pif.prim_valid), 64'd0);
    check("basic_busy_fin", 64'(busy), 64'd0);
    check("basic_addr", 64'(rd_addr), 64'h4);
    @(posedge clk); #1;
    check("basic_done_pulse", 64'(done), 64'd0);
    check("basic_prims", 64'(prim_cnt - p0), 64'd1);

    // Backpressure
    load_rec(8'h08, 32'h4000_0ABC, 32'h0010_0020, 32'h0030_0040, 32'h0050_0060);
    push_exp(2'b01, 30'hABC, 32'h0010_0020, 32'h0030_0040, 32'h0050_0060);
    pif.prim_ready = 1'b0;
    d0 = done_cnt;
    do_start(8'h08, 7'd1);
    wait_valid("bp");
    snap.t = pif.prim_type; snap.a = pif.prim_attr;
    snap.v0 = pif.prim_v0; snap.v1 = pif.prim_v1; snap.v2 = pif.prim_v2;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_hold", 64'(pif.prim_valid && pif.prim_type == snap.t &&
            pif.prim_attr == snap.a && pif.prim_v0 == snap.v0 &&
            pif.prim_v1 == snap.v1 && pif.prim_v2 == snap.v2), 64'd1);
    end
    pif.prim_ready = 1'b1;
    wait_done("bp");
    check("bp_dones", 64'(done_cnt - d0), 64'd1);

    // END marker early stop
    load_rec(8'h20, 32'h0000_0011, 32'h1, 32'h2, 32'h3);
    load_rec(8'h24, 32'hC000_0000, 32'h0, 32'h0, 32'h0);
    load_rec(8'h28, 32'h0000_0022, 32'h4, 32'h5, 32'h6);
    push_exp(2'b00, 30'h11, 32'h1, 32'h2, 32'h0);
    p0 = prim_cnt; d0 = done_cnt;
    do_start(8'h20, 7'd3);
    wait_done("end");
    check("end_prims", 64'(prim_cnt - p0), 64'd1);
    check("end_dones", 64'(done_cnt - d0), 64'd1);
    check("end_err", 64'(err), 64'd0);
    check("end_addr", 64'(rd_addr), 64'h24);

    // Reserved type at top of RAM, wrap to address 0
    load_rec(8'hFC, 32'h8000_0000, 32'h0, 32'h0, 32'h0);
    load_rec(8'h00, 32'h0000_0033, 32'h0007_0008, 32'h0009_000A, 32'hFFFF_FFFF);
    push_exp(2'b00, 30'h33, 32'h0007_0008, 32'h0009_000A, 32'h0);
    p0 = prim_cnt;
    do_start(8'hFE, 7'd2);
    wait_done("wrap");
    check("wrap_err", 64'(err), 64'd1);
    check("wrap_prims", 64'(prim_cnt - p0), 64'd1);
    check("wrap_addr", 64'(rd_addr), 64'h04);

    // Zero count: immediate done, err cleared
    p0 = prim_cnt;
    do_start(8'h10, 7'd0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_err_clr", 64'(err), 64'd0);
    @(posedge clk); #1;
    check("zero_done_pulse", 64'(done), 64'd0);
    check("zero_prims", 64'(prim_cnt - p0), 64'd0);

    // Start while busy is ignored
    load_rec(8'h30, 32'h4000_0001, 32'hA, 32'hB, 32'hC);
    load_rec(8'h34, 32'h0000_0002, 32'hD, 32'hE, 32'hF);
    push_exp(2'b01, 30'h1, 32'hA, 32'hB, 32'hC);
    push_exp(2'b00, 30'h2, 32'hD, 32'hE, 32'h0);
    p0 = prim_cnt; d0 = done_cnt;
    do_start(8'h30, 7'd2);
    @(posedge clk); #1;
    do_start(8'h80, 7'd5);
    wait_done("busy_start");
    check("busy_start_prims", 64'(prim_cnt - p0), 64'd2);
    check("busy_start_dones", 64'(done_cnt - d0), 64'd1);
    check("busy_start_addr", 64'(rd_addr), 64'h38);

    // Async reset while a primitive is presented
    load_rec(8'h50, 32'h8000_0000, 32'h0, 32'h0, 32'h0);
    load_rec(8'h54, 32'h0000_0044, 32'h1, 32'h2, 32'h3);
    pif.prim_ready = 1'b0;
    d0 = done_cnt;
    do_start(8'h50, 7'd2);
    wait_valid("arst");
    check("arst_err_pre", 64'(err), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(pif.prim_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_err", 64'(err), 64'd0);
    check("arst_addr", 64'(rd_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_done", 64'(done_cnt - d0), 64'd0);
    pif.prim_ready = 1'b1;
    push_exp(2'b01, 30'h1, 32'hA, 32'hB, 32'hC);
    p0 = prim_cnt;
    do_start(8'h30, 7'd1);
    wait_done("arst_restart");
    check("arst_restart_prims", 64'(prim_cnt - p0), 64'd1);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
